// File: rtl/i2s_rx.sv
`timescale 1ns/1ps
// i2s_rx -- Philips I2S receiver, stereo pair output with valid/ready handshake.
//
// Ports
//    clk12m     in   system clock, all logic on its rising edge
//    reset_n    in   asynchronous active-low reset
//    SCK        in   I2S bit clock (asynchronous, >= 8 clk12m cycles per period)
//    LRCLK      in   I2S word select (asynchronous), 0 = left, 1 = right
//    SDATA      in   I2S serial data, MSB first (asynchronous)
//    sample_l   out  last complete left word, MSB-aligned
//    sample_r   out  last complete right word, MSB-aligned
//    out_valid  out  sample_l/sample_r hold a new stereo pair
//    out_ready  in   consumer accepts the pair when high together with out_valid
//    overrun    out  sticky: a pair was overwritten before it was accepted
//
// Build option
//    I2S_RX_OFFSET_BIN_EN  when defined, words are output in offset binary
//                          (MSB inverted); otherwise two's complement unchanged.
module i2s_rx #(
   parameter int unsigned DATA_W = 16
) (
   input  logic              clk12m,
   input  logic              reset_n,
   input  logic              SCK,
   input  logic              LRCLK,
   input  logic              SDATA,
   output logic [DATA_W-1:0] sample_l,
   output logic [DATA_W-1:0] sample_r,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              overrun
);

   localparam int unsigned         CNT_W   = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(DATA_W);
   localparam logic [DATA_W-1:0]   MSB_ONE = {1'b1, {(DATA_W-1){1'b0}}};

`ifdef I2S_RX_OFFSET_BIN_EN
   localparam logic [DATA_W-1:0]   FMT_MASK = MSB_ONE;
`else
   localparam logic [DATA_W-1:0]   FMT_MASK = '0;
`endif

   typedef enum logic [1:0] {
      ST_SYNC,
      ST_LEFT,
      ST_RIGHT
   } state_t;

   state_t state_q, state_d;

   // [0],[1] form the synchronizer; sck_q[2] is the edge-detect register
   logic [2:0]        sck_q;
   logic [1:0]        lr_q;
   logic [1:0]        sd_q;

   logic              lr_prev_q, lr_prev_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] hold_l_q, hold_l_d;
   logic [DATA_W-1:0] sample_l_q, sample_l_d;
   logic [DATA_W-1:0] sample_r_q, sample_r_d;
   logic              valid_q, valid_d;
   logic              ovr_q, ovr_d;

   logic              strobe;
   logic              lr_s;
   logic              sd_s;
   logic              lr_chg;
   logic [DATA_W-1:0] word;
   logic              load_hold;
   logic              load_pair;

   assign strobe = sck_q[1] & ~sck_q[2];
   assign lr_s   = lr_q[1];
   assign sd_s   = sd_q[1];
   assign lr_chg = strobe & (lr_s != lr_prev_q);

   // Current channel word including this strobe's bit. The bit lands at
   // position DATA_W-1-cnt; once cnt saturates the shift yields zero, so
   // surplus bits are dropped and short words stay MSB-aligned, zero-filled.
   always_comb begin
      word = shift_q | ((sd_s ? MSB_ONE : '0) >> cnt_q);
   end

   // Bit gathering
   always_comb begin
      lr_prev_d = lr_prev_q;
      shift_d   = shift_q;
      cnt_d     = cnt_q;
      if (strobe) begin
         lr_prev_d = lr_s;
         if (lr_chg) begin
            shift_d = '0;
            cnt_d   = '0;
         end else begin
            shift_d = word;
            if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      end
   end

   // Channel framing FSM
   always_comb begin
      state_d   = state_q;
      load_hold = 1'b0;
      load_pair = 1'b0;
      unique case (state_q)
         ST_SYNC: begin
            if (lr_chg && !lr_s) state_d = ST_LEFT;
         end
         ST_LEFT: begin
            if (lr_chg && lr_s) begin
               state_d   = ST_RIGHT;
               load_hold = 1'b1;
            end
         end
         ST_RIGHT: begin
            if (lr_chg && !lr_s) begin
               state_d   = ST_LEFT;
               load_pair = 1'b1;
            end
         end
         default: state_d = ST_SYNC;
      endcase
   end

   // Output pair and handshake
   always_comb begin
      hold_l_d   = hold_l_q;
      sample_l_d = sample_l_q;
      sample_r_d = sample_r_q;
      valid_d    = valid_q;
      ovr_d      = ovr_q;
      if (load_hold) begin
         hold_l_d = word;
      end
      if (load_pair) begin
         sample_l_d = hold_l_q ^ FMT_MASK;
         sample_r_d = word ^ FMT_MASK;
         valid_d    = 1'b1;
         if (valid_q && !out_ready) begin
            ovr_d = 1'b1;
         end
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk12m or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_SYNC;
         sck_q      <= '0;
         lr_q       <= '0;
         sd_q       <= '0;
         lr_prev_q  <= 1'b0;
         shift_q    <= '0;
         cnt_q      <= '0;
         hold_l_q   <= '0;
         sample_l_q <= '0;
         sample_r_q <= '0;
         valid_q    <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         sck_q      <= {sck_q[1:0], SCK};
         lr_q       <= {lr_q[0], LRCLK};
         sd_q       <= {sd_q[0], SDATA};
         lr_prev_q  <= lr_prev_d;
         shift_q    <= shift_d;
         cnt_q      <= cnt_d;
         hold_l_q   <= hold_l_d;
         sample_l_q <= sample_l_d;
         sample_r_q <= sample_r_d;
         valid_q    <= valid_d;
         ovr_q      <= ovr_d;
      end
   end

   assign sample_l  = sample_l_q;
   assign sample_r  = sample_r_q;
   assign out_valid = valid_q;
   assign overrun   = ovr_q;

endmodule
